// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and types used by the writeback arbiter
// Provides XLEN, the default writeback requester count, and the writeback
// request record (valid, destination register, result data).
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int WB_NUM_REQ = 4;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational two-slot rotating writeback picker
// Ports:
//   valid    [NREQ]    requester has a result pending
//   rd       [NREQ][5] destination register per requester
//   ptr      [PW]      rotation start index
//   gnt0/1   [NREQ]    one-hot slot 0 / slot 1 winners (zero if slot empty)
//   idx0/1   [PW]      binary index of each winner
//   found0/1           slot is occupied
//   conflict           a valid requester was passed over only because its rd
//                      equals slot 0's rd
module wb_rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]      valid,
    input  logic [NREQ-1:0][4:0] rd,
    input  logic [PW-1:0]        ptr,
    output logic [NREQ-1:0]      gnt0,
    output logic [NREQ-1:0]      gnt1,
    output logic [PW-1:0]        idx0,
    output logic [PW-1:0]        idx1,
    output logic                 found0,
    output logic                 found1,
    output logic                 conflict
);

    // Requester index visited at rotation step k.
    logic [PW-1:0] ord [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_ord
        assign ord[k] = PW'((int'(ptr) + k) % NREQ);
    end

    logic [4:0] rd0;

    always_comb begin
        gnt0     = '0;
        gnt1     = '0;
        idx0     = '0;
        idx1     = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        conflict = 1'b0;
        rd0      = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (valid[ord[k]]) begin
                if (!found0) begin
                    found0         = 1'b1;
                    idx0           = ord[k];
                    rd0            = rd[ord[k]];
                    gnt0[ord[k]]   = 1'b1;
                end else if (!found1) begin
                    // Only requesters seen while slot 1 is still open can be
                    // deferred by a same-rd match; later ones lost on capacity.
                    if (rd[ord[k]] != rd0) begin
                        found1       = 1'b1;
                        idx1         = ord[k];
                        gnt1[ord[k]] = 1'b1;
                    end else begin
                        conflict = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port register-file writeback arbiter
// Optional macro WB_ARB_STATS_EN adds stat_grants / stat_conflicts counters.
// Ports:
//   clk, rst_n (async, active-low)
//   hold                      freeze: no grants, ptr held
//   req_valid/req_rd/req_data per-requester result
//   req_ready                 combinational grant
//   wr_en_n/rd_addr_n/rd_data_n  registered write ports 0 and 1
//   stat_grants/stat_conflicts   (WB_ARB_STATS_EN only) wrapping counters
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ = WB_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][4:0]     req_rd,
    input  logic [NREQ-1:0][XLEN-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wr_en_0,
    output logic [4:0]               rd_addr_0,
    output logic [XLEN-1:0]          rd_data_0,
    output logic                     wr_en_1,
    output logic [4:0]               rd_addr_1,
    output logic [XLEN-1:0]          rd_data_1
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]              stat_grants,
    output logic [31:0]              stat_conflicts
`endif
);

    localparam int PW = $clog2(NREQ);

    wb_req_t req [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign req[i] = '{valid: req_valid[i], rd: req_rd[i], data: req_data[i]};
    end

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] gnt0, gnt1;
    logic [PW-1:0]   idx0, idx1;
    logic            found0, found1, conflict;

    wb_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .valid    (req_valid),
        .rd       (req_rd),
        .ptr      (ptr),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .idx0     (idx0),
        .idx1     (idx1),
        .found0   (found0),
        .found1   (found1),
        .conflict (conflict)
    );

    logic fire0, fire1;
    assign fire0 = rst_n && !hold && found0;
    assign fire1 = rst_n && !hold && found1;

    assign req_ready = (rst_n && !hold) ? (gnt0 | gnt1) : '0;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : PW'(int'(i) + 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            wr_en_0   <= 1'b0;
            rd_addr_0 <= '0;
            rd_data_0 <= '0;
            wr_en_1   <= 1'b0;
            rd_addr_1 <= '0;
            rd_data_1 <= '0;
        end else begin
            // rd=0 grants consume the slot but never write x0.
            wr_en_0 <= fire0 && (req[idx0].rd != 5'd0);
            wr_en_1 <= fire1 && (req[idx1].rd != 5'd0);
            if (fire0) begin
                rd_addr_0 <= req[idx0].rd;
                rd_data_0 <= req[idx0].data;
                ptr       <= found1 ? next_idx(idx1) : next_idx(idx0);
            end
            if (fire1) begin
                rd_addr_1 <= req[idx1].rd;
                rd_data_1 <= req[idx1].data;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_grants    <= stat_grants + 32'(fire0) + 32'(fire1);
            stat_conflicts <= stat_conflicts + 32'(conflict && !hold);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import riscv_pkg::*;

    localparam int NREQ = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      hold = 1'b0;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0][4:0]      req_rd = '0;
    logic [NREQ-1:0][XLEN-1:0] req_data = '0;
    logic [NREQ-1:0]           req_ready;
    logic                      wr_en_0, wr_en_1;
    logic [4:0]                rd_addr_0, rd_addr_1;
    logic [XLEN-1:0]           rd_data_0, rd_data_1;
`ifdef WB_ARB_STATS_EN
    logic [31:0]               stat_grants, stat_conflicts;
`endif

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en_0   (wr_en_0),
        .rd_addr_0 (rd_addr_0),
        .rd_data_0 (rd_data_0),
        .wr_en_1   (wr_en_1),
        .rd_addr_1 (rd_addr_1),
        .rd_data_1 (rd_data_1)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        tests++;
        if ({wr_en_0, wr_en_1, rd_addr_0, rd_addr_1} !== 12'd0) begin
            fails++; $display("FAIL reset_ports got %b %b %0d %0d want 0", wr_en_0, wr_en_1, rd_addr_0, rd_addr_1);
        end
        tests++;
        if (dut.ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr got %0d want 0", dut.ptr); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid   = 4'b0001;
        req_rd[0]   = 5'd5;
        req_data[0] = 32'hA5A5_0001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tests++;
        if ({wr_en_0, rd_addr_0, rd_data_0, wr_en_1} !== {1'b1, 5'd5, 32'hA5A5_0001, 1'b0}) begin
            fails++; $display("FAIL single_write got en0=%b rd=%0d data=%h en1=%b want 1 5 a5a50001 0",
                              wr_en_0, rd_addr_0, rd_data_0, wr_en_1);
        end
        tick();
        tests++;
        if (wr_en_0 !== 1'b0 || rd_addr_0 !== 5'd5) begin
            fails++; $display("FAIL single_idle got en0=%b rd=%0d want 0 5", wr_en_0, rd_addr_0);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        req_valid   = 4'b0110;
        req_rd[1]   = 5'd3;
        req_rd[2]   = 5'd3;
        req_data[1] = 32'h1111_0001;
        req_data[2] = 32'h2222_0002;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL conflict_ready1 got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        #1;
        tests++;
        if ({wr_en_0, rd_addr_0, rd_data_0, wr_en_1} !== {1'b1, 5'd3, 32'h1111_0001, 1'b0}) begin
            fails++; $display("FAIL conflict_write1 got en0=%b rd=%0d data=%h en1=%b", wr_en_0, rd_addr_0, rd_data_0, wr_en_1);
        end
`ifdef WB_ARB_STATS_EN
        tests++;
        if (stat_conflicts !== 32'd1) begin fails++; $display("FAIL conflict_stat got %0d want 1", stat_conflicts); end
`endif
        tests++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL conflict_ready2 got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        tests++;
        if ({wr_en_0, rd_addr_0, rd_data_0, wr_en_1} !== {1'b1, 5'd3, 32'h2222_0002, 1'b0}) begin
            fails++; $display("FAIL conflict_write2 got en0=%b rd=%0d data=%h en1=%b", wr_en_0, rd_addr_0, rd_data_0, wr_en_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] exp_ready [3];
        logic [1:0]      exp_ptr   [3];
        exp_ready[0] = 4'b0011; exp_ready[1] = 4'b1100; exp_ready[2] = 4'b0011;
        exp_ptr[0]   = 2'd0;    exp_ptr[1]   = 2'd2;    exp_ptr[2]   = 2'd0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_rd[i]   = 5'(i + 1);
            req_data[i] = 32'hC0DE_0000 + 32'(i);
        end
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (req_ready !== exp_ready[c] || dut.ptr !== exp_ptr[c]) begin
                fails++; $display("FAIL b2b_grant%0d got ready=%b ptr=%0d want %b %0d", c, req_ready, dut.ptr, exp_ready[c], exp_ptr[c]);
            end
            tick();
            // Port 0 carries the lower index of the pair in rotation order.
            tests++;
            if ({wr_en_0, rd_addr_0, wr_en_1, rd_addr_1, rd_data_1} !==
                {1'b1, 5'(exp_ptr[c] + 1), 1'b1, 5'(exp_ptr[c] + 2), 32'hC0DE_0000 + 32'(exp_ptr[c] + 1)}) begin
                fails++; $display("FAIL b2b_write%0d got en0=%b rd0=%0d en1=%b rd1=%0d d1=%h",
                                  c, wr_en_0, rd_addr_0, wr_en_1, rd_addr_1, rd_data_1);
            end
        end
`ifdef WB_ARB_STATS_EN
        tests++;
        if (stat_grants !== 32'd6) begin fails++; $display("FAIL b2b_stat got %0d want 6", stat_grants); end
`endif
        req_valid = '0;
    endtask

    task automatic test_rd_zero();
        do_reset();
        req_valid   = 4'b0011;
        req_rd[0]   = 5'd0;
        req_rd[1]   = 5'd7;
        req_data[1] = 32'h0000_7777;
        #1;
        tests++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL rdzero_ready got %b want 0011", req_ready); end
        tick();
        req_valid = '0;
        tests++;
        if ({wr_en_0, wr_en_1, rd_addr_1, rd_data_1} !== {1'b0, 1'b1, 5'd7, 32'h0000_7777}) begin
            fails++; $display("FAIL rdzero_write got en0=%b en1=%b rd1=%0d d1=%h", wr_en_0, wr_en_1, rd_addr_1, rd_data_1);
        end
    endtask

    task automatic test_hold();
        do_reset();
        hold        = 1'b1;
        req_valid   = 4'b1000;
        req_rd[3]   = 5'd9;
        req_data[3] = 32'h9999_0009;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin fails++; $display("FAIL hold_ready%0d got %b want 0000", c, req_ready); end
            tick();
            tests++;
            if (wr_en_0 !== 1'b0 || wr_en_1 !== 1'b0 || dut.ptr !== 2'd0) begin
                fails++; $display("FAIL hold_state%0d got en0=%b en1=%b ptr=%0d want 0 0 0", c, wr_en_0, wr_en_1, dut.ptr);
            end
        end
        hold = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL hold_release got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        tests++;
        if ({wr_en_0, rd_addr_0, rd_data_0, dut.ptr} !== {1'b1, 5'd9, 32'h9999_0009, 2'd0}) begin
            fails++; $display("FAIL hold_write got en0=%b rd=%0d data=%h ptr=%0d", wr_en_0, rd_addr_0, rd_data_0, dut.ptr);
        end
    endtask

    task automatic test_reset_mid();
        // Reset lands before the capturing edge: nothing may be written.
        do_reset();
        req_valid = 4'b0001;
        req_rd[0] = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
        tests++;
        if (wr_en_0 !== 1'b0 || wr_en_1 !== 1'b0) begin
            fails++; $display("FAIL rstmid_nowrite got en0=%b en1=%b want 0 0", wr_en_0, wr_en_1);
        end
        // Reset after capture clears the registered write at once.
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tests++;
        if (wr_en_0 !== 1'b1) begin fails++; $display("FAIL rstmid_captured got %b want 1", wr_en_0); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (wr_en_0 !== 1'b0 || rd_addr_0 !== 5'd0) begin
            fails++; $display("FAIL rstmid_async got en0=%b rd=%0d want 0 0", wr_en_0, rd_addr_0);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (wr_en_0 !== 1'b0) begin fails++; $display("FAIL rstmid_after got %b want 0", wr_en_0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_rd_zero();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
